// File: rtl/io_pkg.sv
// Shared state encoding, default DMA segment bases and result width for the
// IO session sequencer and its watchdog.
package io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_IMG = 3'd1,
      ST_LOAD_FLT = 3'd2,
      ST_READY    = 3'd3,
      ST_COMPUTE  = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERROR    = 3'd6
   } io_seq_state_t;

   localparam logic [15:0] IO_IMG_BASE = 16'h0000;
   localparam logic [15:0] IO_FLT_BASE = 16'h4000;
   localparam int          IO_RES_W    = 4;

   function automatic logic is_load_state(input io_seq_state_t s);
      return (s == ST_LOAD_IMG) || (s == ST_LOAD_FLT);
   endfunction

   function automatic logic is_busy_state(input io_seq_state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
   endfunction

endpackage

// File: rtl/io_watchdog.sv
// Compute-phase watchdog: counts enabled cycles from a clear and flags the
// cycle in which the count reaches TIMEOUT-1.
module io_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_r;

   // Cycle counter; saturates at LAST so it never wraps while enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (enable && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/io_sequencer.sv
// Session controller for the IO path: image load, filter load, compute and
// result capture, with a watchdog on the compute phase. Control only.
module io_sequencer
   import io_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(IO_IMG_BASE),
   parameter logic [ADDR_W-1:0] FLT_BASE = ADDR_W'(IO_FLT_BASE),
   parameter int                TIMEOUT  = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                cnn,
   input  logic                seg_done,
   input  logic                cnn_done,
   input  logic [IO_RES_W-1:0] cnn_result,
   output logic                dec_en,
   output logic [ADDR_W-1:0]   dma_base,
   output logic                base_load,
   output logic                cnn_start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [IO_RES_W-1:0] result
);

   io_seq_state_t       state_r;
   io_seq_state_t       next_s;
   logic                load_q_r;
   logic                load_rise_s;
   logic                entering_s;
   logic                capture_s;
   logic                wd_clear_s;
   logic                wd_enable_s;
   logic                wd_expired_s;

   logic                dec_en_r;
   logic [ADDR_W-1:0]   dma_base_r;
   logic                base_load_r;
   logic                cnn_start_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic [IO_RES_W-1:0] result_r;

   assign load_rise_s = load & ~load_q_r;
   assign entering_s  = (next_s != state_r);
   assign wd_clear_s  = entering_s && (next_s == ST_COMPUTE);
   assign wd_enable_s = (state_r == ST_COMPUTE);

   io_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear_s),
      .enable  (wd_enable_s),
      .expired (wd_expired_s)
   );

   // State register and load-edge history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         load_q_r <= 1'b0;
      end else begin
         state_r  <= next_s;
         load_q_r <= load;
      end
   end

   // Next-state logic; a completion in the watchdog's last cycle beats the timeout
   always_comb begin
      next_s    = state_r;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_rise_s) next_s = ST_LOAD_IMG;
            else             next_s = state_r;
         end
         ST_LOAD_IMG: begin
            if (seg_done) next_s = ST_LOAD_FLT;
            else          next_s = state_r;
         end
         ST_LOAD_FLT: begin
            if (seg_done) next_s = ST_READY;
            else          next_s = state_r;
         end
         ST_READY: begin
            if (load_rise_s) next_s = ST_LOAD_IMG;
            else if (cnn)    next_s = ST_COMPUTE;
            else             next_s = state_r;
         end
         ST_COMPUTE: begin
            if (cnn_done) begin
               next_s    = ST_DONE;
               capture_s = 1'b1;
            end else if (wd_expired_s) begin
               next_s = ST_ERROR;
            end else begin
               next_s = state_r;
            end
         end
         ST_DONE: begin
            next_s = ST_IDLE;
         end
         ST_ERROR: begin
            if (load_rise_s) next_s = ST_LOAD_IMG;
            else             next_s = state_r;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // Output registers track the state being entered, so they align with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_en_r    <= 1'b0;
         dma_base_r  <= IMG_BASE;
         base_load_r <= 1'b0;
         cnn_start_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         result_r    <= {IO_RES_W{1'b0}};
      end else begin
         dec_en_r    <= is_load_state(next_s);
         base_load_r <= entering_s && is_load_state(next_s);
         cnn_start_r <= wd_clear_s;
         busy_r      <= is_busy_state(next_s);
         done_r      <= (next_s == ST_DONE);
         err_r       <= (next_s == ST_ERROR);
         if (entering_s && (next_s == ST_LOAD_IMG)) begin
            dma_base_r <= IMG_BASE;
         end else if (entering_s && (next_s == ST_LOAD_FLT)) begin
            dma_base_r <= FLT_BASE;
         end else begin
            dma_base_r <= dma_base_r;
         end
         if (capture_s) begin
            result_r <= cnn_result;
         end else begin
            result_r <= result_r;
         end
      end
   end

   assign dec_en    = dec_en_r;
   assign dma_base  = dma_base_r;
   assign base_load = base_load_r;
   assign cnn_start = cnn_start_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign result    = result_r;

endmodule
